ws2812_chain_driver: RTL and testbench
======================================

Name: ws2812_chain_driver

Overview:
- Parametrised successor to the single-strand WS2812B bit driver.
- Serialises a chain of NUM_LEDS pixels of CHANNELS bytes each. Supports 3-channel GRB (WS2812B) and 4-channel GRBW (SK6812).
- Pulls pixels from an upstream frame source through an index request/valid handshake, with a one-pixel prefetch buffer so bits are emitted gap-free.
- Sits between the pattern/frame memory and the LED data pin; timing is set by cycle-count parameters.

Parameters:
- NUM_LEDS, 20, pixels per frame (>=1).
- CHANNELS, 3, bytes per pixel (3 or 4).
- T0H_CYCLES, 40, high time of a 0 bit.
- T0L_CYCLES, 85, low time of a 0 bit.
- T1H_CYCLES, 80, high time of a 1 bit.
- T1L_CYCLES, 45, low time of a 1 bit.
- RESET_CYCLES, 5000, latch low time (50 us at 100 MHz).

Ports:
- clk_in  input  1  system clock, 100 MHz nominal.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  level; start a new frame whenever IDLE.
- force_reset  input  1  pulse; abort frame, enter latch period.
- color_in  input  8*CHANNELS  pixel data in wire order; MSB is sent first.
- color_valid  input  1  single-cycle pulse; answers the outstanding request.
- strand_out  output  1  serial data to the LED chain.
- next_led_request  output  max(1,$clog2(NUM_LEDS))  index of the requested pixel.
- request_valid  output  1  single-cycle pulse qualifying next_led_request.
- frame_done  output  1  single-cycle pulse after the last bit of a complete frame.
- underrun  output  1  sticky; set when data arrives late.
- status_clear  input  1  pulse; clears underrun.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - strand_out=0, request_valid=0, next_led_request=0, frame_done=0, underrun=0.
  - Internal buffers are empty and the FSM is in RESET_LOW; busy=1.
  - A full latch period is therefore guaranteed after reset.
- FSM states: RESET_LOW, IDLE, WAIT_FIRST, BIT_HIGH, BIT_LOW.
- RESET_LOW:
  - strand_out=0 for RESET_CYCLES cycles, then go to IDLE.
  - Any color_valid received here is dropped.
- IDLE:
  - If enable=1: request_valid=1 and next_led_request=0 for one cycle, then go to WAIT_FIRST.
  - No timeout in WAIT_FIRST; the FSM waits indefinitely.
- WAIT_FIRST:
  - On color_valid, capture color_in into the shift register and set bit count to 8*CHANNELS.
  - The cycle after capture, go to BIT_HIGH.
  - In that same cycle, if NUM_LEDS>1, pulse request_valid for index 1.
- BIT_HIGH: strand_out=1 for T1H_CYCLES or T0H_CYCLES (chosen by the current MSB), then go to BIT_LOW.
- BIT_LOW:
  - strand_out=0 for T1L_CYCLES or T0L_CYCLES.
  - On the final low cycle, shift left. If bits remain, go to BIT_HIGH.
- End of pixel (final low cycle of the last bit):
  - Last index: pulse frame_done, go to RESET_LOW.
  - Holding register full, or color_valid in this same cycle (bypass): load the pixel and go to BIT_HIGH with no idle cycle. If more pixels remain, issue the next request 1 cycle after the load.
  - Otherwise (underrun): set underrun, keep strand_out low, go to RESET_LOW. No frame_done. The pending request is abandoned.
- color_valid arriving while a request is outstanding and the FSM is mid-pixel fills the holding register.
- Handshake rules:
  - At most one request outstanding.
  - color_valid with no outstanding request is ignored.
- force_reset, from any state:
  - strand_out is forced to 0 on the next cycle.
  - Shift/holding registers are cleared and the outstanding request is cancelled; go to RESET_LOW (full count restarts).
  - Takes priority over simultaneous color_valid and frame completion (no frame_done).
- enable is sampled only in IDLE; deasserting it mid-frame lets the frame finish.
- underrun clears on status_clear. A set on the same cycle as status_clear wins.
- Index counter wraps to 0 at each frame start. next_led_request holds its last value between pulses.
- Counter width: $clog2(max timing parameter + 1), and at least $clog2(RESET_CYCLES+1).

Optional Feature:
- Macro: WS2812_CHAIN_DRIVER_BRIGHTNESS_EN.
- When defined:
  - Adds input port brightness [7:0].
  - Each byte of color_in is scaled at capture (shift register or holding register) as (c*(brightness+1))>>8, registered with no extra latency.
  - brightness=255 passes data unchanged; brightness=0 yields 0.
- When undefined: port absent, data passed unmodified.

Test Plan:
- Bench parameters for all cases: NUM_LEDS=3, CHANNELS=3, T0H=4, T0L=8, T1H=8, T1L=4, RESET=50.
- Reset release: strand_out=0 for 50 cycles, busy=1, then IDLE (busy=0); no request issued while enable=0.
- Normal frame: enable=1, answer requests 0,1,2 within 5 cycles with 0xFF0000, 0x00FF00, 0x0000AA.
  - strand_out shows 72 bits of 12-cycle period; highs are 8/4 cycles matching the data.
  - No gaps between pixels; frame_done pulses once, followed by 50 low cycles.
- Underrun: withhold the response to index 1.
  - After 24 bits, strand_out stays low and underrun=1; no frame_done, RESET_LOW entered.
  - A late color_valid is ignored; status_clear returns underrun to 0.
- Bypass edge: return pixel 1's color_valid exactly on pixel 0's final low cycle → continuous output, underrun=0.
- force_reset mid-bit of pixel 1 → strand_out=0 the next cycle, 50-cycle latch, then a fresh request for index 0.
- With WS2812_CHAIN_DRIVER_BRIGHTNESS_EN and brightness=127, input 0xFF8000 → transmitted 0x7F4000.

Source files
------------

// File: rtl/ws2812_chain_driver.sv
// ws2812_chain_driver: gap-free WS2812/SK6812 chain serialiser with one-pixel prefetch; optional WS2812_CHAIN_DRIVER_BRIGHTNESS_EN scales bytes at capture
module ws2812_chain_driver #(
  parameter int NUM_LEDS     = 20,
  parameter int CHANNELS     = 3,
  parameter int T0H_CYCLES   = 40,
  parameter int T0L_CYCLES   = 85,
  parameter int T1H_CYCLES   = 80,
  parameter int T1L_CYCLES   = 45,
  parameter int RESET_CYCLES = 5000,
  localparam int IW = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1,
  localparam int DW = 8 * CHANNELS
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          force_reset,
  input  logic [DW-1:0] color_in,
  input  logic          color_valid,
`ifdef WS2812_CHAIN_DRIVER_BRIGHTNESS_EN
  input  logic [7:0]    brightness,
`endif
  input  logic          status_clear,
  output logic          strand_out,
  output logic [IW-1:0] next_led_request,
  output logic          request_valid,
  output logic          frame_done,
  output logic          underrun,
  output logic          busy
);
  localparam int TMAX = T0H_CYCLES > T0L_CYCLES ? (T0H_CYCLES > T1H_CYCLES ? (T0H_CYCLES > T1L_CYCLES ? T0H_CYCLES : T1L_CYCLES) : (T1H_CYCLES > T1L_CYCLES ? T1H_CYCLES : T1L_CYCLES)) : (T0L_CYCLES > T1H_CYCLES ? (T0L_CYCLES > T1L_CYCLES ? T0L_CYCLES : T1L_CYCLES) : (T1H_CYCLES > T1L_CYCLES ? T1H_CYCLES : T1L_CYCLES));
  localparam int CW = $clog2(TMAX + 1) > $clog2(RESET_CYCLES + 1) ? $clog2(TMAX + 1) : $clog2(RESET_CYCLES + 1);
  localparam int BW = $clog2(DW + 1);
  typedef enum logic [2:0] {RESET_LOW, IDLE, WAIT_FIRST, BIT_HIGH, BIT_LOW} state_t;
  state_t        st_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] shift_q, hold_q, col_d;
  logic [BW-1:0] bits_q;
  logic [IW-1:0] cur_q, idx_q;
  logic          hold_full_q, out_q, rv_q, fd_q, ur_q, strand_q;
  logic [CW-1:0] th_d, tl_d;
  logic          take_d, last_d, more_d;
`ifdef WS2812_CHAIN_DRIVER_BRIGHTNESS_EN
  for (genvar i = 0; i < CHANNELS; i++) begin : g_scale
    assign col_d[8*i +: 8] = 8'((16'(color_in[8*i +: 8]) * (16'(brightness) + 16'd1)) >> 8);
  end
`else
  assign col_d = color_in;
`endif
  assign th_d   = shift_q[DW-1] ? CW'(T1H_CYCLES - 1) : CW'(T0H_CYCLES - 1);
  assign tl_d   = shift_q[DW-1] ? CW'(T1L_CYCLES - 1) : CW'(T0L_CYCLES - 1);
  assign take_d = color_valid && out_q;
  assign last_d = cur_q == IW'(NUM_LEDS - 1);
  assign more_d = int'(cur_q) + 2 < NUM_LEDS;
  assign strand_out       = strand_q;
  assign next_led_request = idx_q;
  assign request_valid    = rv_q;
  assign frame_done       = fd_q;
  assign underrun         = ur_q;
  assign busy             = st_q != IDLE;
  // Frame FSM: latch period, pixel fetch handshake, bit timing and prefetch refill
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      st_q        <= RESET_LOW;
      cnt_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      bits_q      <= '0;
      cur_q       <= '0;
      idx_q       <= '0;
      hold_full_q <= 1'b0;
      out_q       <= 1'b0;
      rv_q        <= 1'b0;
      fd_q        <= 1'b0;
      ur_q        <= 1'b0;
      strand_q    <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      fd_q <= 1'b0;
      if (status_clear) ur_q <= 1'b0;
      if (force_reset) begin
        st_q        <= RESET_LOW;
        cnt_q       <= '0;
        strand_q    <= 1'b0;
        shift_q     <= '0;
        hold_q      <= '0;
        hold_full_q <= 1'b0;
        out_q       <= 1'b0;
      end else case (st_q)
        RESET_LOW:
          if (cnt_q == CW'(RESET_CYCLES - 1)) begin
            st_q  <= IDLE;
            cnt_q <= '0;
          end else cnt_q <= cnt_q + CW'(1);
        IDLE:
          if (enable) begin
            st_q  <= WAIT_FIRST;
            rv_q  <= 1'b1;
            idx_q <= '0;
            cur_q <= '0;
            out_q <= 1'b1;
          end
        WAIT_FIRST:
          if (take_d) begin
            shift_q  <= col_d;
            bits_q   <= BW'(DW);
            out_q    <= NUM_LEDS > 1;
            st_q     <= BIT_HIGH;
            strand_q <= 1'b1;
            cnt_q    <= '0;
            if (NUM_LEDS > 1) begin
              rv_q  <= 1'b1;
              idx_q <= IW'(1);
            end
          end
        BIT_HIGH: begin
          if (take_d) begin
            hold_q      <= col_d;
            hold_full_q <= 1'b1;
            out_q       <= 1'b0;
          end
          if (cnt_q == th_d) begin
            st_q     <= BIT_LOW;
            strand_q <= 1'b0;
            cnt_q    <= '0;
          end else cnt_q <= cnt_q + CW'(1);
        end
        BIT_LOW: begin
          if (take_d) begin
            hold_q      <= col_d;
            hold_full_q <= 1'b1;
            out_q       <= 1'b0;
          end
          if (cnt_q != tl_d) cnt_q <= cnt_q + CW'(1);
          else begin
            cnt_q   <= '0;
            shift_q <= shift_q << 1;
            bits_q  <= bits_q - BW'(1);
            if (bits_q != BW'(1)) begin
              st_q     <= BIT_HIGH;
              strand_q <= 1'b1;
            end else if (last_d) begin
              fd_q  <= 1'b1;
              out_q <= 1'b0;
              st_q  <= RESET_LOW;
            end else if (hold_full_q || take_d) begin
              shift_q     <= hold_full_q ? hold_q : col_d;
              hold_full_q <= 1'b0;
              out_q       <= more_d;
              bits_q      <= BW'(DW);
              cur_q       <= cur_q + IW'(1);
              st_q        <= BIT_HIGH;
              strand_q    <= 1'b1;
              if (more_d) begin
                rv_q  <= 1'b1;
                idx_q <= cur_q + IW'(2);
              end
            end else begin
              ur_q  <= 1'b1;
              out_q <= 1'b0;
              st_q  <= RESET_LOW;
            end
          end
        end
        default: st_q <= RESET_LOW;
      endcase
    end
endmodule

// File: tb/tb_ws2812_chain_driver.sv
// tb_ws2812_chain_driver: directed checks of latch timing, frame serialisation, underrun, bypass and abort
module tb_ws2812_chain_driver;
  logic clk_in = 1'b0, rst_n = 1'b0, enable = 1'b0, force_reset = 1'b0, color_valid = 1'b0, status_clear = 1'b0;
  logic [23:0] color_in = '0;
  logic strand_out, request_valid, frame_done, underrun, busy;
  logic [1:0] next_led_request;
`ifdef WS2812_CHAIN_DRIVER_BRIGHTNESS_EN
  logic [7:0] brightness = 8'd255;
`endif
  int total = 0, bad = 0, nc = 0;
  logic st_s [8192];
  logic fd_s [8192];
  logic bz_s [8192];
  logic ur_s [8192];

  ws2812_chain_driver #(
    .NUM_LEDS(3), .CHANNELS(3), .T0H_CYCLES(4), .T0L_CYCLES(8),
    .T1H_CYCLES(8), .T1L_CYCLES(4), .RESET_CYCLES(50)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .enable(enable), .force_reset(force_reset),
    .color_in(color_in), .color_valid(color_valid),
`ifdef WS2812_CHAIN_DRIVER_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .status_clear(status_clear), .strand_out(strand_out),
    .next_led_request(next_led_request), .request_valid(request_valid),
    .frame_done(frame_done), .underrun(underrun), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  // Per-cycle trace of outputs, sampled 2 time units after each rising edge
  always begin
    @(posedge clk_in);
    #2;
    if (nc < 8192) begin
      st_s[nc] = strand_out;
      fd_s[nc] = frame_done;
      bz_s[nc] = busy;
      ur_s[nc] = underrun;
    end
    nc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ones(input int a, input int b, input int w);
    int n = 0;
    for (int i = a; i < b; i++) n += (w == 0) ? int'(st_s[i]) : int'(fd_s[i]);
    return n;
  endfunction

  task automatic wait_req(input string tag, input logic [1:0] idx);
    int n = 0;
    while (!request_valid && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    chk({tag, "_seen"}, 32'(request_valid), 32'd1);
    chk({tag, "_idx"}, 32'(next_led_request), 32'(idx));
  endtask

  task automatic pulse_cv(input logic [23:0] d, output int s);
    color_in = d;
    color_valid = 1'b1;
    s = nc;
    @(negedge clk_in);
    color_valid = 1'b0;
  endtask

  task automatic chk_px(input string tag, input int s, input int p, input logic [23:0] exp);
    logic [23:0] v = '0;
    int shape = 0;
    int b;
    for (int i = 0; i < 24; i++) begin
      b = s + 12 * (24 * p + i);
      v = {v[22:0], st_s[b+4]};
      if (!(st_s[b] === 1'b1 && st_s[b+3] === 1'b1 && st_s[b+7] === st_s[b+4] && st_s[b+8] === 1'b0 && st_s[b+11] === 1'b0)) shape++;
    end
    chk(tag, 32'(v), 32'(exp));
    chk({tag, "_shape"}, 32'(shape), 32'd0);
  endtask

  initial begin
    int n, hi, s, t, f, r;
    repeat (3) @(negedge clk_in);
    chk("rst_strand", 32'(strand_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_rv", 32'(request_valid), 32'd0);
    chk("rst_idx", 32'(next_led_request), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_ur", 32'(underrun), 32'd0);
    rst_n = 1'b1;
    n = 0;
    hi = 0;
    while (busy && n < 200) begin
      @(negedge clk_in);
      n++;
      hi += int'(strand_out);
    end
    chk("latch_len", 32'(n), 32'd50);
    chk("latch_low", 32'(hi), 32'd0);
    hi = 0;
    repeat (10) begin
      @(negedge clk_in);
      hi += int'(request_valid);
    end
    chk("idle_no_req", 32'(hi), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    // normal frame
    enable = 1'b1;
    wait_req("n0", 2'd0);
    enable = 1'b0;
    repeat (2) @(negedge clk_in);
    pulse_cv(24'hFF0000, s);
    wait_req("n1", 2'd1);
    repeat (3) @(negedge clk_in);
    pulse_cv(24'h00FF00, t);
    wait_req("n2", 2'd2);
    repeat (4) @(negedge clk_in);
    pulse_cv(24'h0000AA, t);
    repeat (720) @(negedge clk_in);
    chk_px("n_px0", s, 0, 24'hFF0000);
    chk_px("n_px1", s, 1, 24'h00FF00);
    chk_px("n_px2", s, 2, 24'h0000AA);
    chk("n_fd_pos", 32'(fd_s[s+864]), 32'd1);
    chk("n_fd_cnt", 32'(ones(s, s + 1000, 1)), 32'd1);
    chk("n_latch_low", 32'(ones(s + 864, s + 914, 0)), 32'd0);
    chk("n_latch_busy", 32'(bz_s[s+913]), 32'd1);
    chk("n_latch_end", 32'(bz_s[s+914]), 32'd0);
    chk("n_ur", 32'(underrun), 32'd0);
    // underrun: index 1 never answered
    enable = 1'b1;
    wait_req("u0", 2'd0);
    enable = 1'b0;
    @(negedge clk_in);
    pulse_cv(24'h123456, s);
    wait_req("u1", 2'd1);
    repeat (400) @(negedge clk_in);
    chk_px("u_px0", s, 0, 24'h123456);
    chk("u_ur_before", 32'(ur_s[s+287]), 32'd0);
    chk("u_ur_set", 32'(ur_s[s+288]), 32'd1);
    chk("u_low", 32'(ones(s + 288, s + 400, 0)), 32'd0);
    chk("u_no_fd", 32'(ones(s, s + 400, 1)), 32'd0);
    chk("u_latch_busy", 32'(bz_s[s+337]), 32'd1);
    chk("u_latch_end", 32'(bz_s[s+338]), 32'd0);
    pulse_cv(24'hFFFFFF, t);
    repeat (20) @(negedge clk_in);
    chk("u_late_ignored", 32'(ones(t, t + 19, 0)), 32'd0);
    chk("u_late_idle", 32'(busy), 32'd0);
    chk("u_sticky", 32'(underrun), 32'd1);
    status_clear = 1'b1;
    @(negedge clk_in);
    status_clear = 1'b0;
    chk("u_cleared", 32'(underrun), 32'd0);
    // bypass: pixel 1 arrives on the final low cycle of pixel 0
    enable = 1'b1;
    wait_req("b0", 2'd0);
    enable = 1'b0;
    repeat (2) @(negedge clk_in);
    pulse_cv(24'hA5C3F0, s);
    wait_req("b1", 2'd1);
    repeat (287) @(negedge clk_in);
    pulse_cv(24'h0F0F0F, t);
    wait_req("b2", 2'd2);
    repeat (3) @(negedge clk_in);
    pulse_cv(24'h81FF7E, t);
    repeat (720) @(negedge clk_in);
    chk_px("b_px0", s, 0, 24'hA5C3F0);
    chk_px("b_px1", s, 1, 24'h0F0F0F);
    chk_px("b_px2", s, 2, 24'h81FF7E);
    chk("b_ur", 32'(underrun), 32'd0);
    chk("b_fd_pos", 32'(fd_s[s+864]), 32'd1);
    chk("b_fd_cnt", 32'(ones(s, s + 1000, 1)), 32'd1);
    // force_reset in the high phase of pixel 1, bit 2
    enable = 1'b1;
    wait_req("f0", 2'd0);
    @(negedge clk_in);
    pulse_cv(24'h00FF00, s);
    wait_req("f1", 2'd1);
    repeat (2) @(negedge clk_in);
    pulse_cv(24'hFFFFFF, t);
    f = s + 314;
    while (nc - 1 < f) @(negedge clk_in);
    chk("f_pre_high", 32'(strand_out), 32'd1);
    force_reset = 1'b1;
    @(negedge clk_in);
    force_reset = 1'b0;
    chk("f_low_next", 32'(strand_out), 32'd0);
    wait_req("f_fresh", 2'd0);
    r = nc - 1;
    enable = 1'b0;
    chk("f_fresh_time", 32'(r), 32'(f + 52));
    chk("f_latch_low", 32'(ones(f + 1, f + 52, 0)), 32'd0);
    chk("f_latch_busy", 32'(bz_s[f+50]), 32'd1);
    chk("f_latch_end", 32'(bz_s[f+51]), 32'd0);
    chk("f_no_fd", 32'(ones(s, f + 52, 1)), 32'd0);
    chk("f_ur", 32'(underrun), 32'd0);
    // answer the fresh request; data path check (scaled when brightness is built in)
    @(negedge clk_in);
`ifdef WS2812_CHAIN_DRIVER_BRIGHTNESS_EN
    brightness = 8'd127;
`endif
    pulse_cv(24'hFF8000, s);
    wait_req("d1", 2'd1);
    repeat (300) @(negedge clk_in);
`ifdef WS2812_CHAIN_DRIVER_BRIGHTNESS_EN
    chk_px("d_px0", s, 0, 24'h7F4000);
`else
    chk_px("d_px0", s, 0, 24'hFF8000);
`endif
    chk("d_ur", 32'(underrun), 32'd1);
    status_clear = 1'b1;
    @(negedge clk_in);
    status_clear = 1'b0;
    chk("d_cleared", 32'(underrun), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
